// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared state encoding, line levels and frame-length helper
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_STOP  = 1'b1;
    localparam logic LINE_START = 1'b0;

    // Clocks from the first start-bit cycle to the last stop-bit cycle.
    function automatic int frame_cycles(input int data_w, input int bit_cycles, input int parity_en);
        return (data_w + 2 + parity_en) * bit_cycles;
    endfunction

endpackage

// File: rtl/serial_frame_tx_if.sv
// rtl/serial_frame_tx_if.sv - request/serial-line bundle between stimulus and transmitter
interface serial_frame_tx_if #(
    parameter int DATA_W = 8
);
    logic              start;
    logic [DATA_W-1:0] data_in;
    logic              tx;
    logic              busy;
    logic              done;

    modport master (output start, data_in, input tx, busy, done);
    modport slave  (input start, data_in, output tx, busy, done);
endinterface

// File: rtl/serial_frame_tx_bit_tick_counter.sv
// rtl/serial_frame_tx_bit_tick_counter.sv - per-bit down counter; tick marks the last clock of a bit
module bit_tick_counter #(
    parameter int BIT_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic tick,
    output logic tick_next
);
    localparam int TW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [TW-1:0] RELOAD = TW'(BIT_CYCLES - 1);

    logic [TW-1:0] timer;

    assign tick = (timer == '0);
    // Lookahead lets the owner register outputs that depend on the next tick.
    assign tick_next = (load || tick) ? (BIT_CYCLES == 1) : (timer == TW'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer <= '0;
        end else if (load || tick) begin
            timer <= RELOAD;
        end else begin
            timer <= timer - TW'(1);
        end
    end
endmodule

// File: rtl/serial_frame_tx.sv
// rtl/serial_frame_tx.sv - parallel-in serial-out frame transmitter (start, data LSB-first, parity, stop)
module serial_frame_tx
    import serial_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int BIT_CYCLES = 4,
    parameter int PARITY_EN  = 0
) (
    input  logic                clk,
    input  logic                reset,
    serial_frame_tx_if.slave    bus
);
    localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_t            state, state_next;
    logic [DATA_W-1:0] shift_q, shift_next;
    logic [IW-1:0]     idx, idx_next;
    logic              par;
    logic              load, tick, tick_next;
    logic              tx_q, busy_q, done_q;
    logic              tx_next, done_next;

    bit_tick_counter #(.BIT_CYCLES(BIT_CYCLES)) u_tick (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .tick      (tick),
        .tick_next (tick_next)
    );

    always_comb begin
        state_next = state;
        shift_next = shift_q;
        idx_next   = idx;
        load       = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    shift_next = bus.data_in;
                    load       = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (tick) begin
                    state_next = DATA;
                    idx_next   = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_next = shift_q >> 1;
                    if (idx == IW'(DATA_W - 1)) begin
                        state_next = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        idx_next = idx + IW'(1);
                    end
                end
            end
            PARITY: begin
                if (tick) state_next = STOP;
            end
            STOP: begin
                if (tick) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are computed from next-state values so they leave flops directly.
    always_comb begin
        tx_next = LINE_IDLE;
        unique case (state_next)
            START:   tx_next = LINE_START;
            DATA:    tx_next = shift_next[0];
            PARITY:  tx_next = par;
            STOP:    tx_next = LINE_STOP;
            default: tx_next = LINE_IDLE;
        endcase
        done_next = (state_next == STOP) && tick_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            shift_q <= '0;
            idx     <= '0;
            par     <= 1'b0;
            tx_q    <= LINE_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_next;
            shift_q <= shift_next;
            idx     <= idx_next;
            if (load) par <= ^bus.data_in;
            tx_q    <= tx_next;
            busy_q  <= (state_next != IDLE);
            done_q  <= done_next;
        end
    end

    assign bus.tx   = tx_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
- Parallel-in, serial-out frame transmitter. It is the driving end for the D-flip-flop/shift-register receiver experiments.
- Accepts a DATA_W-bit word on a start request and shifts it out on a single line: start bit, data LSB-first, optional even parity, stop bit.
- Each bit is held for BIT_CYCLES clocks.
- Sits between lab stimulus logic (switches/counters) and the serial line into the receiver flip-flop chain.

Parameters:
- DATA_W, 8, number of data bits per frame (1..16)
- BIT_CYCLES, 4, clocks per serial bit (>=1)
- PARITY_EN, 0, 1 inserts an even-parity bit between the last data bit and the stop bit

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  frame request, sampled only in IDLE
- data_in  input  DATA_W  word to send, captured in the cycle start is accepted
- tx  output  1  serial line; idles high
- busy  output  1  high while a frame is in progress (any state other than IDLE)
- done  output  1  one-cycle pulse in the final clock of the stop bit

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low.
- Reset (reset=0, immediate, no clock needed):
  - tx=1, busy=0, done=0.
  - State IDLE; shift register and bit timer cleared.
  - Takes effect mid-frame as well; the partial frame is abandoned.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1, busy=0.
  - On a rising edge with start=1: latch data_in into the shift register, load the bit timer with BIT_CYCLES-1, go to START.
  - tx=0 and busy=1 are visible from the cycle after acceptance (latency 1 clock).
- Bit timing:
  - The timer counts down each clock; a bit ends when the timer is 0.
  - On bit end the timer reloads to BIT_CYCLES-1 and the FSM advances.
  - Every bit therefore lasts exactly BIT_CYCLES clocks.
- START: tx=0 for one bit time, then go to DATA with bit index 0.
- DATA:
  - tx = shift_reg[0].
  - On bit end: shift right and increment the index.
  - After index DATA_W-1, go to PARITY if PARITY_EN=1, else go to STOP.
- PARITY: tx = XOR of the latched word (even parity: total count of ones in data plus parity bit is even); lasts one bit time.
- STOP:
  - tx=1 for one bit time.
  - done=1 in the last clock of STOP only; next state IDLE.
- Frame length: (DATA_W+2+PARITY_EN)*BIT_CYCLES clocks from the first tx=0 cycle to the last stop cycle.
- start while busy=1 (including the done cycle) is ignored; no queuing.
- With start held high continuously, frames repeat with exactly one IDLE clock (tx=1) between each stop bit and the next start bit.
- data_in changes after acceptance do not affect the frame in flight.
- BIT_CYCLES=1: every state lasts one clock; timer logic degenerates with no off-by-one.
- Counter widths:
  - Bit timer is clog2(BIT_CYCLES) bits, minimum 1.
  - Bit index is clog2(DATA_W) bits, minimum 1.
  - No wrap beyond the terminal values.

Decomposition:
- Shared package serial_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP)
  - constants for idle and stop line level (1) and start level (0)
  - the frame-length function, reused by the receiver bench
- Sub-module bit_tick_counter:
  - parameter BIT_CYCLES
  - inputs clk, reset, load
  - output tick (timer==0)
  - The FSM and shift register stay in the top module.

Test Plan:
- Reset then basic frame: reset low 30 ns then high, BIT_CYCLES=4, PARITY_EN=0, data_in=8'hA5, 1-clock start pulse.
  - Required: tx per 4-clock bit = 0,1,0,1,0,0,1,0,1,1; busy high for 40 clocks; done high only in clock 40; tx=1 afterwards.
- Parity frame: PARITY_EN=1, data 8'h07 (three ones).
  - Required: parity bit=1 after data bits 1,1,1,0,0,0,0,0; frame 44 clocks.
  - Repeat with 8'h00: parity=0.
- Ignored start: pulse start with data 8'h3C at clock 10 of an 8'hA5 frame.
  - Required: 8'hA5 frame unchanged, no second frame, done pulses once.
- Back-to-back: start held high, data 8'hFF then 8'h00.
  - Required: exactly one tx=1 idle clock between the stop bit and the next start bit; done pulses 41 clocks apart.
- Reset mid-frame: assert reset low during data bit 3 (between clock edges).
  - Required: tx=1, busy=0, done=0 immediately without waiting for a clock; after release, stays IDLE until a new start.
- BIT_CYCLES=1, DATA_W=4, data 4'b1001.
  - Required: tx sequence 0,1,0,0,1,1 over 6 consecutive clocks; done in clock 6.
